crc_frame_engine: RTL and testbench

- Streaming, frame-aware parallel CRC engine. It is the parametrised successor of the team's fixed-width crc_parallel.
- Accepts DATA_WIDTH-bit beats over a valid/ready handshake, with start-of-frame and end-of-frame markers and a partial last beat.
- Computes a configurable CRC per frame. Optionally compares it against an expected value.
- Presents one result per frame on a backpressured output. Sits between packet sources and link/framing logic.

---
 rtl/crc_frame_engine.sv | 142 ++++++++++++++
 tb/tb_crc_frame_engine.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_frame_engine.sv
// Frame-aware streaming CRC engine: one unrolled CRC update per accepted beat,
// one backpressured result (CRC + compare flag) per frame.
module crc_frame_engine #(
    parameter int                    POLY_WIDTH = 8,
    parameter logic [POLY_WIDTH-1:0] POLY       = 'h07,
    parameter logic [POLY_WIDTH-1:0] INIT       = 'h00,
    parameter bit                    REFLECT    = 1'b0,
    parameter logic [POLY_WIDTH-1:0] XOR_OUT    = 'h00,
    parameter int                    DATA_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [DATA_WIDTH-1:0]          s_data,
    input  logic                           s_sop,
    input  logic                           s_eop,
    input  logic [$clog2(DATA_WIDTH/8):0]  s_bytes,
    input  logic [POLY_WIDTH-1:0]          s_exp_crc,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [POLY_WIDTH-1:0]          m_crc,
    output logic                           m_match,
    output logic [15:0]                    frame_cnt,
    output logic [15:0]                    abort_cnt
);

    localparam int NB = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, ACCUM, RESULT} state_t;

    state_t                state_q, state_d;
    logic [POLY_WIDTH-1:0] crc_q, crc_d, crc_next, crc_fin;
    logic                  live_q;
    logic                  take, done, abort;
    int                    beat_bytes;

    // Bit-serial CRC over the first nbytes bytes, byte 0 first, unrolled in one cycle.
    function automatic logic [POLY_WIDTH-1:0] crc_update(
        input logic [POLY_WIDTH-1:0] crc_in,
        input logic [DATA_WIDTH-1:0] data,
        input int                    nbytes
    );
        logic [POLY_WIDTH-1:0] c;
        logic [7:0]            byt;
        logic                  fb;
        c = crc_in;
        for (int i = 0; i < NB; i++) begin
            if (i < nbytes) begin
                byt = data[DATA_WIDTH-1-8*i -: 8];
                for (int b = 0; b < 8; b++) begin
                    fb = c[POLY_WIDTH-1] ^ (REFLECT ? byt[b] : byt[7-b]);
                    c  = c << 1;
                    if (fb) c = c ^ POLY;
                end
            end
        end
        return c;
    endfunction

    function automatic logic [POLY_WIDTH-1:0] crc_finalize(input logic [POLY_WIDTH-1:0] c);
        logic [POLY_WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < POLY_WIDTH; k++) begin
            r[k] = REFLECT ? c[POLY_WIDTH-1-k] : c[k];
        end
        return r ^ XOR_OUT;
    endfunction

    // live_q holds s_ready low until the first edge after reset release.
    assign s_ready = live_q && (state_q != RESULT);
    assign m_valid = (state_q == RESULT);
    assign take    = s_valid && s_ready;

    always_comb begin
        beat_bytes = NB;
        if (s_eop && (s_bytes != '0) && (int'(s_bytes) <= NB)) begin
            beat_bytes = int'(s_bytes);
        end
        crc_next = crc_update(s_sop ? INIT : crc_q, s_data, beat_bytes);
        crc_fin  = crc_finalize(crc_next);
    end

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        done    = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (take && s_sop) begin
                    crc_d = crc_next;
                    if (s_eop) begin
                        done    = 1'b1;
                        state_d = RESULT;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (take) begin
                    abort = s_sop;
                    crc_d = crc_next;
                    if (s_eop) begin
                        done    = 1'b1;
                        state_d = RESULT;
                    end
                end
            end
            RESULT: begin
                if (m_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            crc_q     <= '0;
            live_q    <= 1'b0;
            m_crc     <= '0;
            m_match   <= 1'b0;
            frame_cnt <= '0;
            abort_cnt <= '0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            live_q  <= 1'b1;
            if (done) begin
                m_crc     <= crc_fin;
                m_match   <= (crc_fin == s_exp_crc);
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (abort && (abort_cnt != 16'hFFFF)) begin
                abort_cnt <= abort_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_crc_frame_engine.sv
// Directed bench for crc_frame_engine: CRC-8 / CRC-16 share one 16-bit stream,
// CRC-32 (reflected) runs on its own 32-bit stream; results go through scoreboards.
module tb_crc_frame_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        s_valid, s_sop, s_eop, m_ready;
    logic [15:0] s_data;
    logic [1:0]  s_bytes;
    logic [7:0]  a_exp;
    logic [15:0] b_exp;

    logic        a_s_ready, a_m_valid, a_m_match;
    logic [7:0]  a_m_crc;
    logic [15:0] a_frame_cnt, a_abort_cnt;

    logic        b_s_ready, b_m_valid, b_m_match;
    logic [15:0] b_m_crc;
    logic [15:0] b_frame_cnt, b_abort_cnt;

    logic        c_valid, c_sop, c_eop, c_m_ready;
    logic [31:0] c_data, c_exp;
    logic [2:0]  c_bytes;
    logic        c_s_ready, c_m_valid, c_m_match;
    logic [31:0] c_m_crc;
    logic [15:0] c_frame_cnt, c_abort_cnt;

    crc_frame_engine u_a (
        .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(a_s_ready),
        .s_data(s_data), .s_sop(s_sop), .s_eop(s_eop), .s_bytes(s_bytes),
        .s_exp_crc(a_exp), .m_valid(a_m_valid), .m_ready(m_ready),
        .m_crc(a_m_crc), .m_match(a_m_match),
        .frame_cnt(a_frame_cnt), .abort_cnt(a_abort_cnt)
    );

    crc_frame_engine #(
        .POLY_WIDTH(16), .POLY(16'h1021), .INIT(16'hFFFF),
        .REFLECT(1'b0), .XOR_OUT(16'h0000), .DATA_WIDTH(16)
    ) u_b (
        .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(b_s_ready),
        .s_data(s_data), .s_sop(s_sop), .s_eop(s_eop), .s_bytes(s_bytes),
        .s_exp_crc(b_exp), .m_valid(b_m_valid), .m_ready(m_ready),
        .m_crc(b_m_crc), .m_match(b_m_match),
        .frame_cnt(b_frame_cnt), .abort_cnt(b_abort_cnt)
    );

    crc_frame_engine #(
        .POLY_WIDTH(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
        .REFLECT(1'b1), .XOR_OUT(32'hFFFFFFFF), .DATA_WIDTH(32)
    ) u_c (
        .clk(clk), .reset_n(reset_n), .s_valid(c_valid), .s_ready(c_s_ready),
        .s_data(c_data), .s_sop(c_sop), .s_eop(c_eop), .s_bytes(c_bytes),
        .s_exp_crc(c_exp), .m_valid(c_m_valid), .m_ready(c_m_ready),
        .m_crc(c_m_crc), .m_match(c_m_match),
        .frame_cnt(c_frame_cnt), .abort_cnt(c_abort_cnt)
    );

    typedef struct {
        logic [31:0] crc;
        logic        match;
        bit          chk;
    } exp_t;

    exp_t qa[$], qb[$], qc[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] crc, input logic match, input bit chk);
        exp_t e;
        e.crc   = crc;
        e.match = match;
        e.chk   = chk;
        return e;
    endfunction

    always @(negedge clk) begin : sb_a
        exp_t e;
        if (a_m_valid && m_ready) begin
            check("a_result_expected", 32'(qa.size() != 0), 32'd1);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                if (e.chk) begin
                    check("a_crc", 32'(a_m_crc), e.crc);
                    check("a_match", 32'(a_m_match), 32'(e.match));
                end
            end
        end
    end

    always @(negedge clk) begin : sb_b
        exp_t e;
        if (b_m_valid && m_ready) begin
            check("b_result_expected", 32'(qb.size() != 0), 32'd1);
            if (qb.size() != 0) begin
                e = qb.pop_front();
                if (e.chk) begin
                    check("b_crc", 32'(b_m_crc), e.crc);
                    check("b_match", 32'(b_m_match), 32'(e.match));
                end
            end
        end
    end

    always @(negedge clk) begin : sb_c
        exp_t e;
        if (c_m_valid && c_m_ready) begin
            check("c_result_expected", 32'(qc.size() != 0), 32'd1);
            if (qc.size() != 0) begin
                e = qc.pop_front();
                if (e.chk) begin
                    check("c_crc", c_m_crc, e.crc);
                    check("c_match", 32'(c_m_match), 32'(e.match));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_beat(input logic [15:0] d, input logic sop, input logic eop,
                             input logic [1:0] nb, input int gap);
        int t;
        s_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        s_data  = d;
        s_sop   = sop;
        s_eop   = eop;
        s_bytes = nb;
        s_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!a_s_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("s_ready_wait", 32'(t < 50), 32'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_sop   = 1'b0;
        s_eop   = 1'b0;
    endtask

    task automatic send_c_beat(input logic [31:0] d, input logic sop, input logic eop,
                               input logic [2:0] nb);
        int t;
        c_data  = d;
        c_sop   = sop;
        c_eop   = eop;
        c_bytes = nb;
        c_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!c_s_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("c_s_ready_wait", 32'(t < 50), 32'd1);
        @(posedge clk);
        #1;
        c_valid = 1'b0;
        c_sop   = 1'b0;
        c_eop   = 1'b0;
    endtask

    task automatic send_frame(input int maxgap);
        logic [15:0] beats [5];
        int          g;
        beats = '{16'h3132, 16'h3334, 16'h3536, 16'h3738, 16'h3900};
        for (int i = 0; i < 5; i++) begin
            g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            send_beat(beats[i], i == 0, i == 4, (i == 4) ? 2'd1 : 2'd0, g);
        end
    endtask

    task automatic expect_result(input int ecnt);
        @(negedge clk);
        check("latency_m_valid", 32'(a_m_valid), 32'd1);
        check("result_s_ready", 32'(a_s_ready), 32'd0);
        check("frame_cnt", 32'(a_frame_cnt), 32'(ecnt));
        @(posedge clk);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_s_ready"},   32'(a_s_ready),   32'd0);
        check({tag, "_m_valid"},   32'(a_m_valid),   32'd0);
        check({tag, "_m_crc"},     32'(a_m_crc),     32'd0);
        check({tag, "_m_match"},   32'(a_m_match),   32'd0);
        check({tag, "_frame_cnt"}, 32'(a_frame_cnt), 32'd0);
        check({tag, "_abort_cnt"}, 32'(a_abort_cnt), 32'd0);
        check({tag, "_b_m_crc"},   32'(b_m_crc),     32'd0);
    endtask

    initial begin
        logic [31:0] cbeats [3];
        int          t;

        reset_n   = 1'b0;
        s_valid   = 1'b0;
        s_sop     = 1'b0;
        s_eop     = 1'b0;
        s_data    = '0;
        s_bytes   = '0;
        a_exp     = 8'hF4;
        b_exp     = 16'h0000;
        m_ready   = 1'b1;
        c_valid   = 1'b0;
        c_sop     = 1'b0;
        c_eop     = 1'b0;
        c_data    = '0;
        c_bytes   = '0;
        c_exp     = 32'hCBF43926;
        c_m_ready = 1'b1;

        // Reset values, then s_ready must wait for the first edge after release.
        #1;
        check_cleared("reset");
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("s_ready_before_edge", 32'(a_s_ready), 32'd0);
        @(negedge clk);
        check("s_ready_after_edge", 32'(a_s_ready), 32'd1);
        @(posedge clk);
        #1;

        // CRC-32 reflected, "123456789" over 32-bit beats.
        cbeats = '{32'h31323334, 32'h35363738, 32'h39000000};
        qc.push_back(mk(32'hCBF43926, 1'b1, 1'b1));
        for (int i = 0; i < 3; i++) begin
            send_c_beat(cbeats[i], i == 0, i == 2, (i == 2) ? 3'd1 : 3'd0);
        end

        // CRC-8 / CRC-16 on "123456789", no gaps.
        qa.push_back(mk(32'hF4, 1'b1, 1'b1));
        qb.push_back(mk(32'h29B1, 1'b0, 1'b1));
        send_frame(0);
        expect_result(1);

        // Backpressure: result held for 10 cycles, wrong expected value.
        a_exp   = 8'hF5;
        m_ready = 1'b0;
        qa.push_back(mk(32'hF4, 1'b0, 1'b1));
        qb.push_back(mk(32'h29B1, 1'b0, 1'b1));
        send_frame(0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_m_valid", 32'(a_m_valid), 32'd1);
            check("hold_s_ready", 32'(a_s_ready), 32'd0);
            check("hold_m_crc",   32'(a_m_crc),   32'hF4);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        @(negedge clk);
        check("release_m_valid", 32'(a_m_valid), 32'd1);
        @(negedge clk);
        check("after_ack_m_valid", 32'(a_m_valid), 32'd0);
        check("after_ack_s_ready", 32'(a_s_ready), 32'd1);
        check("after_ack_frame_cnt", 32'(a_frame_cnt), 32'd2);
        @(posedge clk);
        #1;

        // Random s_valid gaps must not change the CRC.
        a_exp = 8'hF4;
        qa.push_back(mk(32'hF4, 1'b1, 1'b1));
        qb.push_back(mk(32'h29B1, 1'b0, 1'b1));
        send_frame(3);
        expect_result(3);

        // Abort: a new sop while a frame is open restarts the CRC.
        qa.push_back(mk(32'hF4, 1'b1, 1'b1));
        qb.push_back(mk(32'h29B1, 1'b0, 1'b1));
        send_beat(16'h3134, 1'b1, 1'b0, 2'd0, 0);
        send_frame(0);
        expect_result(4);
        check("abort_cnt", 32'(a_abort_cnt), 32'd1);

        // Non-sop beat in IDLE is discarded.
        send_beat(16'h3132, 1'b0, 1'b1, 2'd0, 0);
        repeat (3) begin
            @(negedge clk);
            check("idle_discard_m_valid", 32'(a_m_valid), 32'd0);
        end
        check("idle_discard_frame_cnt", 32'(a_frame_cnt), 32'd4);
        check("idle_discard_abort_cnt", 32'(a_abort_cnt), 32'd1);
        @(posedge clk);
        #1;

        // Single-beat frames "12": s_bytes=0 and s_bytes beyond the beat both mean full.
        a_exp = 8'h72;
        qa.push_back(mk(32'h72, 1'b1, 1'b1));
        qb.push_back(mk(32'h0, 1'b0, 1'b0));
        send_beat(16'h3132, 1'b1, 1'b1, 2'd0, 0);
        expect_result(5);
        qa.push_back(mk(32'h72, 1'b1, 1'b1));
        qb.push_back(mk(32'h0, 1'b0, 1'b0));
        send_beat(16'h3132, 1'b1, 1'b1, 2'd3, 0);
        expect_result(6);
        a_exp = 8'hF4;

        // Reset in ACCUM clears everything at once.
        send_beat(16'h3132, 1'b1, 1'b0, 2'd0, 0);
        reset_n = 1'b0;
        #1;
        check_cleared("rst_accum");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset in RESULT: no result is emitted for that frame.
        m_ready = 1'b0;
        send_frame(0);
        @(negedge clk);
        check("pre_reset_m_valid", 32'(a_m_valid), 32'd1);
        check("pre_reset_m_match", 32'(a_m_match), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check_cleared("rst_result");
        @(negedge clk);
        reset_n = 1'b1;
        m_ready = 1'b1;
        @(posedge clk);
        #1;

        // Clean frame after reset.
        qa.push_back(mk(32'hF4, 1'b1, 1'b1));
        qb.push_back(mk(32'h29B1, 1'b0, 1'b1));
        send_frame(0);
        expect_result(1);

        t = 0;
        while ((qa.size() != 0 || qb.size() != 0 || qc.size() != 0) && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("qa_drained", 32'(qa.size()), 32'd0);
        check("qb_drained", 32'(qb.size()), 32'd0);
        check("qc_drained", 32'(qc.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
